// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg: shared types, default coefficients and sizing helper for the CIC compensation FIR
package cic_comp_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_TAPS       = 7;
    localparam int DEF_COEF_WIDTH = 12;
    localparam int DEF_COEF_FRAC  = 10;

    typedef logic signed [DEF_COEF_WIDTH-1:0] coef_t;

    // Symmetric inverse-sinc taps; they sum to 2^DEF_COEF_FRAC for unity DC gain
    localparam coef_t COEF [DEF_TAPS] = '{
        coef_t'(-16), coef_t'(32), coef_t'(-96), coef_t'(1184),
        coef_t'(-96), coef_t'(32), coef_t'(-16)
    };

    typedef enum logic [1:0] {IDLE, MAC, RND, OUT} comp_state_e;

    // Wide enough that the full TAPS-term sum of products can never overflow
    function automatic int acc_width(int w, int cw, int t);
        return w + cw + $clog2(t) + 1;
    endfunction

endpackage

// File: rtl/cic_comp_fir_if.sv
// cic_comp_fir_if: input and output valid/ready streams of the compensation FIR
interface cic_comp_fir_if
    import cic_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sat;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sat
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sat
    );
endinterface

// File: rtl/comp_hist_buf.sv
// comp_hist_buf: TAPS-deep circular sample history with one write port and a combinational indexed read
module comp_hist_buf
    import cic_comp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAPS  = DEF_TAPS,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [TAPS];

    // Clearing on reset makes the first outputs after reset partial convolutions against zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd_data = mem[ra];
endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: inverse-sinc compensation FIR using one time-multiplexed MAC over a circular history
module cic_comp_fir
    import cic_comp_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TAPS       = DEF_TAPS,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int COEF_FRAC  = DEF_COEF_FRAC
) (
    input  logic           clk,
    input  logic           rst,
    cic_comp_fir_if.slave  bus
);
    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = acc_width(WIDTH, COEF_WIDTH, TAPS);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(2 ** WIDTH - 1);
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    comp_state_e             state;
    logic [AW-1:0]           wp;
    logic [AW-1:0]           rd;
    logic [AW-1:0]           k;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod;
    logic signed [ACC_W-1:0] r;
    logic [WIDTH-1:0]        hist_q;
    logic                    accept;

    assign bus.in_ready = (state == IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    comp_hist_buf #(.WIDTH(WIDTH), .TAPS(TAPS)) u_hist (
        .clk     (clk),
        .rst     (rst),
        .we      (accept),
        .wa      (wp),
        .wd      (bus.in_data),
        .ra      (rd),
        .rd_data (hist_q)
    );

    // Samples are unsigned, so they are zero-extended before the signed multiply
    assign prod = ACC_W'(COEF[k]) * ACC_W'($signed({1'b0, hist_q}));
    // Round half up, then drop the coefficient fraction with an arithmetic shift
    assign r    = (acc + HALF) >>> COEF_FRAC;

    // Sequencer: accept, TAPS MAC cycles from newest to oldest sample, round/clamp, hold until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wp            <= '0;
            rd            <= '0;
            k             <= '0;
            acc           <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rd    <= wp;
                    k     <= '0;
                    acc   <= '0;
                    state <= MAC;
                end
                MAC: begin
                    acc   <= acc + prod;
                    k     <= k + 1'b1;
                    rd    <= (rd == '0) ? LAST : rd - 1'b1;
                    state <= (k == LAST) ? RND : MAC;
                end
                RND: begin
                    bus.out_sat   <= (r < 0) || (r > MAXV);
                    bus.out_data  <= (r < 0) ? '0 : (r > MAXV) ? '1 : r[WIDTH-1:0];
                    bus.out_valid <= 1'b1;
                    wp            <= (wp == LAST) ? '0 : wp + 1'b1;
                    state         <= OUT;
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Compensation FIR placed directly downstream of CIC_filter in decimator mode (DnI=1). It runs at the decimated sample rate.
- Corrects the CIC passband droop using a symmetric inverse-sinc FIR.
- Uses a single time-multiplexed multiply-accumulate over a circular sample history.
- Data moves on valid/ready handshakes on both sides. Input and output data are unsigned; coefficients are signed.

Parameters:
- WIDTH, 8: input/output sample width (unsigned), matching the CIC_filter WIDTH.
- TAPS, 7: number of FIR taps; must be >= 2.
- COEF_WIDTH, 12: signed coefficient width.
- COEF_FRAC, 10: coefficient fraction bits. Coefficients sum to 2^COEF_FRAC, giving unity DC gain.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_data  in  WIDTH  unsigned sample from the CIC decimator.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample.
- out_data  out  WIDTH  compensated sample, unsigned and saturated.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- out_sat  out  1  the current out_data was clamped; qualified by out_valid.

Behaviour:
- Reset (rst high at a posedge): state=IDLE, all history entries=0, wp=0, acc=0, out_data=0, out_valid=0, out_sat=0. in_ready is forced 0 while rst is high. Reset mid-operation abandons the sample in flight; no output is produced for it.
- FSM states: IDLE, MAC, RND, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: write in_data to hist[wp], set rd=wp, k=0, acc=0, go to MAC.
- MAC (exactly TAPS cycles):
  - Each cycle: acc += signed(COEF[k]) * zero-extended hist[rd].
  - Then k++, and rd decrements with wrap (0 -> TAPS-1). k=0 always pairs with the newest sample.
  - After k=TAPS-1 has accumulated, go to RND.
- RND (1 cycle):
  - r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC, an arithmetic shift (round half up).
  - If r<0: out_data=0 and out_sat=1.
  - If r>2^WIDTH-1: out_data=2^WIDTH-1 and out_sat=1.
  - Otherwise out_data=r and out_sat=0.
  - Set out_valid=1, advance wp (wrap TAPS-1 -> 0), go to OUT.
- OUT:
  - out_data and out_sat are held stable while out_valid=1 && !out_ready.
  - On out_ready: out_valid=0, go to IDLE.
  - in_ready=0 in MAC, RND and OUT. Upstream must hold in_valid/in_data; no sample is lost or duplicated.
- Latency and throughput:
  - out_valid rises TAPS+1 clocks after the accepting edge.
  - Minimum sample period is TAPS+3 clocks (10 at defaults). The CIC RATE must be >= TAPS+3.
- Accumulator width:
  - ACC_W = WIDTH + COEF_WIDTH + $clog2(TAPS) + 1, signed.
  - No overflow is possible inside acc.
- History start-up: entries are zero after reset, so the first TAPS-1 outputs are partial convolutions. No special casing.

Decomposition:
- Package cic_comp_pkg holds:
  - typedef coef_t (signed [COEF_WIDTH-1:0]);
  - constant COEF array; default for TAPS=7 is {-16, 32, -96, 1184, -96, 32, -16}, sum 1024;
  - function acc_width();
  - state enum comp_state_e {IDLE, MAC, RND, OUT}.
- One sub-module: comp_hist_buf. It is a TAPS-deep circular register buffer with a write port and an indexed combinational read port, plus synchronous clear on rst. The FSM, MAC and saturation logic stay in cic_comp_fir.

Test Plan:
- Reset, then stream constant 100 with out_ready=1. Required outputs:
  - sample 1 -> 0 with out_sat=1 (acc=-1600);
  - sample 2 -> 2 with out_sat=0;
  - from sample 7 on -> 100 with out_sat=0 (DC gain 1).
- Impulse: 255 followed by zeros. Required outputs in order: 0(sat), 8, 0(sat), 255(sat), 0(sat), 8, 0(sat), then 0 with out_sat=0.
- Latency/throughput: in_valid held high, out_ready=1. Required: out_valid rises exactly 8 clocks after the accept edge, and consecutive accepts are exactly 10 clocks apart.
- Backpressure: out_ready=0 for 20 cycles with in_valid=1 and in_data=50. Required: out_data/out_sat stable, in_ready=0, and the held 50 is accepted exactly once after out_ready rises.
- Reset mid-MAC (after 7 DC samples of 100): assert rst for 1 cycle in MAC. Required: out_valid=0 and no output for the aborted sample. The next sample of 100 yields 0 with out_sat=1, proving the history was cleared.
- Wrap-around: 20 random samples. Required: each output matches a reference model computed with the rounding/saturation rule above. This includes samples written at wp=TAPS-1 and read across the wrap.
